npc_irq_ctrl: RTL

- Next-PC selection and interrupt-entry controller, directly upstream of the PC register; drives its PCin (npc) and PCWr (pc_wr).
- Chooses between sequential, branch, jump, interrupt-vector and exception-return addresses.
- Latches external interrupt requests, saves the return address (EPC) and cause, and sequences entry into and exit from a non-nested handler.

---
 rtl/npc_irq_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/npc_irq_ctrl.sv
// Next-PC select and non-nested interrupt entry/exit sequencer feeding the PC register.
// Optional per-line vector slots are enabled with `define IRQ_VECTOR_TABLE_EN.
module npc_irq_ctrl #(
    parameter int unsigned N_IRQ    = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_cur,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             eret,
    input  logic [N_IRQ-1:0] irq,
    output logic [31:0]      npc,
    output logic             pc_wr,
    output logic             flush,
    output logic [31:0]      epc,
    output logic [2:0]       cause,
    output logic             in_isr
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 3;

    typedef enum logic [1:0] {RUN, TAKE, ISR, RET} state_t;

    state_t            state, state_nxt;
    logic [N_IRQ-1:0]  irq_d;
    logic [N_IRQ-1:0]  pending;
    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  win_mask;
    logic [N_IRQ-1:0]  ack_mask;
    logic [CW-1:0]     win_idx;
    logic [XLEN-1:0]   seq;
    logic [XLEN-1:0]   redir;
    logic [XLEN-1:0]   vector;
    logic              take_req;
    logic              ack;
    logic              epc_ld;

    assign rise     = irq & ~irq_d;
    assign seq      = pc_cur + XLEN'(4);
    assign redir    = jump ? jump_target : (br_taken ? br_target : seq);
    assign take_req = (|pending) & ~stall & ~in_isr;
    assign ack_mask = ack ? win_mask : '0;

    // Lowest pending index wins
    always_comb begin
        win_idx = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                win_idx = CW'(i);
            end
        end
        win_mask = N_IRQ'(1) << win_idx;
    end

`ifdef IRQ_VECTOR_TABLE_EN
    assign vector = VEC_BASE + (XLEN'(win_idx) << 3);
`else
    assign vector = VEC_BASE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        npc       = redir;
        pc_wr     = ~stall;
        flush     = (jump | br_taken) & ~stall;
        ack       = 1'b0;
        epc_ld    = 1'b0;
        case (state)
            RUN: begin
                if (take_req) begin
                    state_nxt = TAKE;
                    epc_ld    = 1'b1;
                end
            end
            TAKE: begin
                npc       = vector;
                pc_wr     = 1'b1;
                flush     = 1'b1;
                ack       = 1'b1;
                state_nxt = ISR;
            end
            ISR: begin
                if (eret && !stall) begin
                    state_nxt = RET;
                end
            end
            RET: begin
                npc       = epc;
                pc_wr     = 1'b1;
                flush     = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // A new edge on the line being acknowledged keeps it pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_d   <= '0;
            pending <= '0;
        end else begin
            irq_d   <= irq;
            pending <= (pending & ~ack_mask) | rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc    <= '0;
            cause  <= '0;
            in_isr <= 1'b0;
        end else begin
            if (epc_ld) begin
                epc <= npc;
            end
            if (ack) begin
                cause  <= win_idx;
                in_isr <= 1'b1;
            end else if (state == RET) begin
                in_isr <= 1'b0;
            end
        end
    end

endmodule
